// File: rtl/demux_pkg.sv
// Shared constants for the registered 1-to-16 demultiplexer.
package demux_pkg;
   localparam int NUM_CH = 16;
   localparam int SEL_W  = 4;

   // Low bit of channel k inside the flattened out_data bus.
   function automatic int ch_lo(input int k, input int w);
      return k * w;
   endfunction
endpackage

// File: rtl/demux_slot.sv
// One-entry holding register for a single output channel.
module demux_slot #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_load,
   input  logic                  i_drain,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_valid
);
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_valid;

   // A load on the same edge as a drain keeps the slot full with the new word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data  <= '0;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_data  <= i_data;
         r_valid <= 1'b1;
      end else if (i_drain) begin
         r_valid <= 1'b0;
      end
   end

   assign o_data  = r_data;
   assign o_valid = r_valid;
endmodule

// File: rtl/demux_1to16_reg.sv
// Registered 1-to-16 demux with per-channel valid/ready holding slots.
// Optional auto-sequenced destination when DEMUX_AUTO_SEL_EN is defined.
module demux_1to16_reg
   import demux_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [DATA_WIDTH-1:0]        in_data,
   input  logic [SEL_W-1:0]             in_sel,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         auto_mode,
   output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
   output logic [NUM_CH-1:0]            out_valid,
   input  logic [NUM_CH-1:0]            out_ready
);
   logic [SEL_W-1:0] w_dest;
   logic             w_accept;

`ifdef DEMUX_AUTO_SEL_EN
   logic [SEL_W-1:0] r_seq;

   // Sequencer only advances on accepts it actually steered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_seq <= '0;
      else if (w_accept && auto_mode)
         r_seq <= r_seq + SEL_W'(1);
   end

   assign w_dest = auto_mode ? r_seq : in_sel;
`else
   logic w_unused_auto;
   assign w_unused_auto = auto_mode;
   assign w_dest        = in_sel;
`endif

   assign in_ready = ~out_valid[w_dest] | out_ready[w_dest];
   assign w_accept = in_valid & in_ready;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      logic w_load;
      logic w_drain;

      assign w_load  = w_accept & (w_dest == SEL_W'(k));
      assign w_drain = out_valid[k] & out_ready[k];

      demux_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
         .clk     (clk),
         .rst_n   (rst_n),
         .i_load  (w_load),
         .i_drain (w_drain),
         .i_data  (in_data),
         .o_data  (out_data[ch_lo(k, DATA_WIDTH) +: DATA_WIDTH]),
         .o_valid (out_valid[k])
      );
   end
endmodule

// File: tb/tb_demux_1to16_reg.sv
// Directed-vector bench for demux_1to16_reg; covers both DEMUX_AUTO_SEL_EN builds.
module tb_demux_1to16_reg;
   logic         clk = 1'b0;
   logic         rst_n;
   logic [7:0]   in_data;
   logic [3:0]   in_sel;
   logic         in_valid;
   logic         in_ready;
   logic         auto_mode;
   logic [127:0] out_data;
   logic [15:0]  out_valid;
   logic [15:0]  out_ready;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   demux_1to16_reg #(.DATA_WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .auto_mode (auto_mode),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge, land 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] ch(input logic [127:0] bus, input int k);
      return bus[k*8 +: 8];
   endfunction

   initial begin
      rst_n     = 1'b0;
      in_data   = 8'hFF;
      in_sel    = 4'd4;
      in_valid  = 1'b1;
      auto_mode = 1'b0;
      out_ready = 16'h0000;
      #1;
      check("rst_valid", out_valid, 16'h0000);
      check("rst_data", out_data, 128'h0);
      check("rst_ready", in_ready, 1'b1);
      step();
      step();
      check("rst_discard", out_valid, 16'h0000);
      in_valid = 1'b0;
      #2 rst_n = 1'b1;

      // Single word to channel 5
      in_sel = 4'd5; in_data = 8'hA5; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      check("ch5_valid", out_valid, 16'h0020);
      check("ch5_data", out_data, 128'hA5 << 40);

      // Backpressure on channel 3
      in_sel = 4'd3; in_data = 8'h33; in_valid = 1'b1;
      step();
      in_data = 8'h44;
      #1 check("ch3_full_ready", in_ready, 1'b0);
      step();
      check("ch3_not_taken", ch(out_data, 3), 8'h33);
      check("ch3_valid_held", out_valid, 16'h0028);
      out_ready[3] = 1'b1;
      #1 check("ch3_ready_up", in_ready, 1'b1);
      step();
      in_valid = 1'b0;
      check("ch3_reload_valid", out_valid[3], 1'b1);
      check("ch3_reload_data", ch(out_data, 3), 8'h44);
      out_ready[3] = 1'b0;

      // Simultaneous drain and load of channel 9
      in_sel = 4'd9; in_data = 8'h11; in_valid = 1'b1;
      step();
      out_ready[9] = 1'b1; in_data = 8'h22;
      #1 check("ch9_ready", in_ready, 1'b1);
      step();
      in_valid = 1'b0;
      check("ch9_valid", out_valid[9], 1'b1);
      check("ch9_data", ch(out_data, 9), 8'h22);

      // Drain everything; idle inputs must be ignored
      out_ready = 16'hFFFF; in_sel = 4'd1; in_data = 8'hEE;
      step();
      check("drain_all", out_valid, 16'h0000);
      check("idle_ch1", ch(out_data, 1), 8'h00);

`ifdef DEMUX_AUTO_SEL_EN
      auto_mode = 1'b1; in_sel = 4'd12; in_valid = 1'b1;
      for (int i = 0; i < 17; i++) begin
         in_data = 8'h10 + 8'(i);
         step();
         check($sformatf("seq%0d_valid", i), out_valid, 16'h1 << (i % 16));
         check($sformatf("seq%0d_data", i), ch(out_data, i % 16), 8'h10 + 8'(i));
      end
      in_valid = 1'b0; auto_mode = 1'b0;
      step();
`else
      auto_mode = 1'b1; in_sel = 4'd12; in_data = 8'hC3; in_valid = 1'b1;
      step();
      in_valid = 1'b0; auto_mode = 1'b0;
      check("nosq_valid", out_valid, 16'h1000);
      check("nosq_data", ch(out_data, 12), 8'hC3);
      step();
`endif

      // Mid-cycle reset with channels 2 and 7 full
      out_ready = 16'h0000;
      in_sel = 4'd2; in_data = 8'h02; in_valid = 1'b1;
      step();
      in_sel = 4'd7; in_data = 8'h07;
      step();
      in_valid = 1'b0;
      check("pre_rst_valid", out_valid, 16'h0084);
      #3 rst_n = 1'b0;
      #1;
      check("mid_rst_valid", out_valid, 16'h0000);
      check("mid_rst_data", out_data, 128'h0);
      check("mid_rst_ready", in_ready, 1'b1);
      #3 rst_n = 1'b1;
      step();
      check("post_rst_valid", out_valid, 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
